hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have parameter MULDIV_CYCLES, default 4, meaning the total EX-stage occupancy of a multiply/divide in cycles (legal 2..15).
REQ-002 The module SHALL have port clk  input  1  rising-edge clock.
REQ-003 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port id_valid  input  1  IF/ID holds a real instruction.
REQ-005 The module SHALL have port id_op1  input  4  IF/ID source register 1.
REQ-006 The module SHALL have port id_op2  input  4  IF/ID source register 2.
REQ-007 The module SHALL have port id_uses_op2  input  1  the IF/ID instruction reads id_op2.
REQ-008 The module SHALL have port idex_mem_read  input  1  the ID/EX instruction is a load.
REQ-009 The module SHALL have port idex_reg_write  input  1  the ID/EX instruction writes a register.
REQ-010 The module SHALL have port idex_dest  input  4  ID/EX destination register.
REQ-011 The module SHALL have port muldiv_start  input  1  the instruction in EX is a multiply/divide.
REQ-012 The module SHALL have port branch_taken  input  1  EX resolved a taken branch or jump.
REQ-013 The module SHALL have port pc_write  output  1  PC update enable.
REQ-014 The module SHALL have port ifid_write  output  1  IF/ID load enable.
REQ-015 The module SHALL have port ifid_flush  output  1  clear IF/ID to a NOP.
REQ-016 The module SHALL have port idex_write  output  1  ID/EX load enable.
REQ-017 The module SHALL have port idex_bubble  output  1  load a NOP into ID/EX.
REQ-018 The module SHALL have port exmem_bubble  output  1  load a NOP into EX/MEM.
REQ-019 The module SHALL have port muldiv_busy  output  1  the FSM is in MULDIV.
REQ-020 The module SHALL have port stall_count  output  16  count of cycles with pc_write=0.

Function
REQ-021 The FSM SHALL have two states, IDLE and MULDIV, plus a 4-bit down-counter cnt.
REQ-022 Control outputs SHALL be combinational from the state, cnt and the current inputs; only the state, cnt and stall_count are registered.
REQ-023 A load-use condition SHALL be: IDLE, id_valid, idex_mem_read, idex_reg_write, idex_dest!=0, and (idex_dest==id_op1, or id_uses_op2 with idex_dest==id_op2).
REQ-024 The default outputs SHALL be: pc_write=1, ifid_write=1, idex_write=1, all flush/bubble outputs 0.
REQ-025 Priority in IDLE SHALL be branch_taken > muldiv_start > load-use.
REQ-026 On branch_taken in IDLE, the unit SHALL assert ifid_flush=1 and idex_bubble=1 for that cycle only, keep pc_write=1, and ignore muldiv_start and load-use.
REQ-027 On load-use in IDLE, the unit SHALL assert pc_write=0, ifid_write=0 and idex_bubble=1 for exactly one cycle, with no state change; forwarding covers the following cycle.
REQ-028 On muldiv_start in IDLE without branch_taken, the unit SHALL assert a freeze that same cycle, go to MULDIV at the next edge, and load cnt=MULDIV_CYCLES-2.
REQ-029 A freeze SHALL be: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1.
REQ-030 In MULDIV with cnt!=0, the unit SHALL freeze and decrement cnt.
REQ-031 In MULDIV with cnt==0, the unit SHALL drive default outputs and return to IDLE at the next edge.
REQ-032 The total number of frozen cycles per multiply/divide SHALL be exactly MULDIV_CYCLES-1.
REQ-033 In MULDIV, branch_taken, muldiv_start and load-use SHALL be ignored.
REQ-034 muldiv_busy SHALL be 1 exactly when the state is MULDIV.
REQ-035 stall_count SHALL increment at every edge where pc_write=0 and SHALL saturate at 16'hFFFF (no wrap).
REQ-036 Register 0 as idex_dest SHALL never cause a load-use stall.

Reset
REQ-037 When rst=1 at an edge, the unit SHALL set state=IDLE, cnt=0 and stall_count=0, including mid-MULDIV.
REQ-038 While rst=1, the unit SHALL drive default outputs and muldiv_busy=0, regardless of the other inputs.
REQ-039 In the first cycle after reset deasserts, the unit SHALL evaluate its inputs as in IDLE.

Verification
REQ-040 Load-use: idex_mem_read=1, idex_reg_write=1, idex_dest=3, id_op1=3, id_valid=1 for 1 cycle -> pc_write=0, ifid_write=0 and idex_bubble=1 for 1 cycle; stall_count=1.
REQ-041 No stall: idex_dest=0 = id_op1, or idex_dest=5 = id_op2 with id_uses_op2=0 -> default outputs, stall_count unchanged.
REQ-042 MULDIV_CYCLES=4, muldiv_start pulse -> freeze for 3 cycles; muldiv_busy=1 for cycles 2-4; default outputs on cycle 4; IDLE on cycle 5; stall_count=3.
REQ-043 branch_taken=1 with muldiv_start=1 and a load-use present -> ifid_flush=1, idex_bubble=1, pc_write=1, no MULDIV entry.
REQ-044 rst=1 on the second MULDIV cycle -> next cycle state=IDLE, muldiv_busy=0, default outputs, stall_count=0.
REQ-045 Saturation: preload via 65535 forced stall cycles, then one more stall -> stall_count stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard control: load-use stall, branch flush, multi-cycle mul/div freeze
module hazard_unit #(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_op1,
    input  logic [3:0]  id_op2,
    input  logic        id_uses_op2,
    input  logic        idex_mem_read,
    input  logic        idex_reg_write,
    input  logic [3:0]  idex_dest,
    input  logic        muldiv_start,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        muldiv_busy,
    output logic [15:0] stall_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        MULDIV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        load_use;

    assign load_use = id_valid && idex_mem_read && idex_reg_write && (idex_dest != 4'd0) &&
                      ((idex_dest == id_op1) || (id_uses_op2 && (idex_dest == id_op2)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        muldiv_busy  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (muldiv_start) begin
                        // The start cycle is itself frozen, so MULDIV covers the remaining MULDIV_CYCLES-2 freezes.
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                        state_d      = MULDIV;
                        cnt_d        = 4'(MULDIV_CYCLES - 2);
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MULDIV: begin
                    muldiv_busy = 1'b1;
                    if (cnt_q != 4'd0) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                        cnt_d        = cnt_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        stall_count_d = stall_count_q;
        if (!pc_write && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_op1;
    logic [3:0]  id_op2;
    logic        id_uses_op2;
    logic        idex_mem_read;
    logic        idex_reg_write;
    logic [3:0]  idex_dest;
    logic        muldiv_start;
    logic        branch_taken;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_write;
    logic        idex_bubble;
    logic        exmem_bubble;
    logic        muldiv_busy;
    logic [15:0] stall_count;

    integer n_cmp = 0;
    integer n_bad = 0;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, muldiv_busy}
    wire [6:0] ctrl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, muldiv_busy};
    localparam logic [6:0] C_DEF      = 7'b1101000;
    localparam logic [6:0] C_LU       = 7'b0001100;
    localparam logic [6:0] C_BR       = 7'b1111100;
    localparam logic [6:0] C_FRZ_IDLE = 7'b0000010;
    localparam logic [6:0] C_FRZ_BUSY = 7'b0000011;
    localparam logic [6:0] C_DEF_BUSY = 7'b1101001;

    hazard_unit #(.MULDIV_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_op1         (id_op1),
        .id_op2         (id_op2),
        .id_uses_op2    (id_uses_op2),
        .idex_mem_read  (idex_mem_read),
        .idex_reg_write (idex_reg_write),
        .idex_dest      (idex_dest),
        .muldiv_start   (muldiv_start),
        .branch_taken   (branch_taken),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_write     (idex_write),
        .idex_bubble    (idex_bubble),
        .exmem_bubble   (exmem_bubble),
        .muldiv_busy    (muldiv_busy),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_valid       = 1'b0;
        id_op1         = 4'd0;
        id_op2         = 4'd0;
        id_uses_op2    = 1'b0;
        idex_mem_read  = 1'b0;
        idex_reg_write = 1'b0;
        idex_dest      = 4'd0;
        muldiv_start   = 1'b0;
        branch_taken   = 1'b0;
    endtask

    task automatic set_load(input logic [3:0] dest, input logic [3:0] op1, input logic [3:0] op2,
                            input logic uses2, input logic valid);
        id_valid       = valid;
        id_op1         = op1;
        id_op2         = op2;
        id_uses_op2    = uses2;
        idex_mem_read  = 1'b1;
        idex_reg_write = 1'b1;
        idex_dest      = dest;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_load(4'd3, 4'd3, 4'd0, 1'b0, 1'b1);
        muldiv_start = 1'b1;
        branch_taken = 1'b1;
        next_cycle();
        #2;
        n_cmp++;
        if (ctrl !== C_DEF) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want %b", ctrl, C_DEF);
        end
        n_cmp++;
        if (stall_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_stall_count got %0d want 0", stall_count);
        end
        next_cycle();
        rst = 1'b0;
        muldiv_start = 1'b0;
        branch_taken = 1'b0;
        #2;
        n_cmp++;
        if (ctrl !== C_LU) begin
            n_bad++;
            $display("FAIL first_cycle_after_reset got %b want %b", ctrl, C_LU);
        end
        next_cycle();
        n_cmp++;
        if (stall_count !== 16'd1) begin
            n_bad++;
            $display("FAIL first_cycle_stall_count got %0d want 1", stall_count);
        end
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        n_cmp++;
        if (stall_count !== 16'd0) begin
            n_bad++;
            $display("FAIL rereset_stall_count got %0d want 0", stall_count);
        end
    endtask

    task automatic test_load_use();
        set_load(4'd3, 4'd3, 4'd0, 1'b0, 1'b1);
        #2;
        n_cmp++;
        if (ctrl !== C_LU) begin
            n_bad++;
            $display("FAIL load_use_op1 got %b want %b", ctrl, C_LU);
        end
        next_cycle();
        clear_inputs();
        #2;
        n_cmp++;
        if (ctrl !== C_DEF) begin
            n_bad++;
            $display("FAIL load_use_one_cycle got %b want %b", ctrl, C_DEF);
        end
        n_cmp++;
        if (stall_count !== 16'd1) begin
            n_bad++;
            $display("FAIL load_use_count got %0d want 1", stall_count);
        end
        next_cycle();
        set_load(4'd7, 4'd2, 4'd7, 1'b1, 1'b1);
        #2;
        n_cmp++;
        if (ctrl !== C_LU) begin
            n_bad++;
            $display("FAIL load_use_op2 got %b want %b", ctrl, C_LU);
        end
        next_cycle();
        clear_inputs();
        n_cmp++;
        if (stall_count !== 16'd2) begin
            n_bad++;
            $display("FAIL load_use_op2_count got %0d want 2", stall_count);
        end
    endtask

    task automatic test_no_stall();
        set_load(4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        #2;
        n_cmp++;
        if (ctrl !== C_DEF) begin
            n_bad++;
            $display("FAIL no_stall_r0 got %b want %b", ctrl, C_DEF);
        end
        next_cycle();
        set_load(4'd5, 4'd1, 4'd5, 1'b0, 1'b1);
        #2;
        n_cmp++;
        if (ctrl !== C_DEF) begin
            n_bad++;
            $display("FAIL no_stall_op2_unused got %b want %b", ctrl, C_DEF);
        end
        next_cycle();
        set_load(4'd6, 4'd6, 4'd0, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (ctrl !== C_DEF) begin
            n_bad++;
            $display("FAIL no_stall_invalid got %b want %b", ctrl, C_DEF);
        end
        next_cycle();
        clear_inputs();
        n_cmp++;
        if (stall_count !== 16'd2) begin
            n_bad++;
            $display("FAIL no_stall_count got %0d want 2", stall_count);
        end
    endtask

    task automatic test_muldiv();
        logic [6:0] exp_ctrl [1:4];
        exp_ctrl[1] = C_FRZ_IDLE;
        exp_ctrl[2] = C_FRZ_BUSY;
        exp_ctrl[3] = C_FRZ_BUSY;
        exp_ctrl[4] = C_DEF_BUSY;
        muldiv_start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #2;
            n_cmp++;
            if (ctrl !== exp_ctrl[c]) begin
                n_bad++;
                $display("FAIL muldiv_cycle%0d got %b want %b", c, ctrl, exp_ctrl[c]);
            end
            next_cycle();
            // hazards presented during MULDIV must be ignored
            branch_taken = 1'b1;
            set_load(4'd4, 4'd4, 4'd0, 1'b0, 1'b1);
        end
        clear_inputs();
        #2;
        n_cmp++;
        if (ctrl !== C_DEF) begin
            n_bad++;
            $display("FAIL muldiv_cycle5_idle got %b want %b", ctrl, C_DEF);
        end
        n_cmp++;
        if (stall_count !== 16'd5) begin
            n_bad++;
            $display("FAIL muldiv_count got %0d want 5", stall_count);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        branch_taken = 1'b1;
        muldiv_start = 1'b1;
        set_load(4'd3, 4'd3, 4'd0, 1'b0, 1'b1);
        #2;
        n_cmp++;
        if (ctrl !== C_BR) begin
            n_bad++;
            $display("FAIL branch_priority got %b want %b", ctrl, C_BR);
        end
        next_cycle();
        clear_inputs();
        #2;
        n_cmp++;
        if (ctrl !== C_DEF) begin
            n_bad++;
            $display("FAIL branch_no_muldiv got %b want %b", ctrl, C_DEF);
        end
        next_cycle();
        muldiv_start = 1'b1;
        set_load(4'd3, 4'd3, 4'd0, 1'b0, 1'b1);
        #2;
        n_cmp++;
        if (ctrl !== C_FRZ_IDLE) begin
            n_bad++;
            $display("FAIL muldiv_over_load_use got %b want %b", ctrl, C_FRZ_IDLE);
        end
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();
        n_cmp++;
        if (stall_count !== 16'd8 || muldiv_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL priority_count got %0d/%b want 8/0", stall_count, muldiv_busy);
        end
    endtask

    task automatic test_reset_mid_muldiv();
        muldiv_start = 1'b1;
        next_cycle();
        muldiv_start = 1'b0;
        rst = 1'b1;
        #2;
        n_cmp++;
        if (ctrl !== C_DEF) begin
            n_bad++;
            $display("FAIL rst_in_muldiv_ctrl got %b want %b", ctrl, C_DEF);
        end
        next_cycle();
        rst = 1'b0;
        #2;
        n_cmp++;
        if (ctrl !== C_DEF || stall_count !== 16'd0) begin
            n_bad++;
            $display("FAIL after_rst_muldiv got %b/%0d want %b/0", ctrl, stall_count, C_DEF);
        end
        next_cycle();
        n_cmp++;
        if (muldiv_busy !== 1'b0 || stall_count !== 16'd0) begin
            n_bad++;
            $display("FAIL after_rst_settled got %b/%0d want 0/0", muldiv_busy, stall_count);
        end
    endtask

    task automatic test_saturation();
        set_load(4'd9, 4'd9, 4'd0, 1'b0, 1'b1);
        repeat (65535) @(posedge clk);
        #1;
        n_cmp++;
        if (stall_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_preload got %h want ffff", stall_count);
        end
        next_cycle();
        #2;
        n_cmp++;
        if (stall_count !== 16'hFFFF || ctrl !== C_LU) begin
            n_bad++;
            $display("FAIL sat_hold got %h/%b want ffff/%b", stall_count, ctrl, C_LU);
        end
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_no_stall();
        test_muldiv();
        test_priority();
        test_reset_mid_muldiv();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
